// File: rtl/fp_adder_pipe_if.sv
// Valid/ready operand and result bundle for fp_adder_pipe; W is derived from EXP_W and MAN_W.
interface fp_adder_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = EXP_W + MAN_W + 1;

  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_fp1;
  logic [W-1:0] i_fp2;
  logic         i_sub;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_fp;
  logic [3:0]   o_flags;

  modport master (output i_valid, i_fp1, i_fp2, i_sub, i_ready,
                  input  o_ready, o_valid, o_fp, o_flags);
  modport slave  (input  i_valid, i_fp1, i_fp2, i_sub, i_ready,
                  output o_ready, o_valid, o_fp, o_flags);
endinterface

// File: rtl/fp_adder_pipe.sv
// 3-stage pipelined IEEE-754 adder/subtractor (unpack/align, add, normalise/round).
// Build macro FP_ADD_RNE_EN selects round-to-nearest-even; default build truncates.
module fp_adder_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fp_adder_pipe_if.slave bus
);
  localparam int unsigned W      = EXP_W + MAN_W + 1;
  localparam int unsigned SW     = MAN_W + 4;   // {hidden, frac, guard, round, sticky}
  localparam int unsigned XW     = EXP_W + 1;   // exponent with overflow headroom
  localparam int unsigned SH_LIM = MAN_W + 3;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // Handshake: only a full output stage that is not drained can block.
  logic v1, v2;
  logic stall_c, en1_c, en2_c, en3_c, in_fire_c;

  assign stall_c     = bus.o_valid && !bus.i_ready;
  assign bus.o_ready = !stall_c;
  assign en3_c       = !stall_c;
  assign en2_c       = !v2 || en3_c;
  assign en1_c       = !v1 || en2_c;
  assign in_fire_c   = bus.i_valid && bus.o_ready;

  // S1: unpack, classify, swap, align
  logic             sa_c, sb_c, sl_c, hl_c, hs_c, swap_c;
  logic             nan_a_c, nan_b_c, snan_a_c, snan_b_c, inf_a_c, inf_b_c;
  logic [EXP_W-1:0] ea_c, eb_c, el_c, es_c, d_c;
  logic [MAN_W-1:0] fa_c, fb_c, fl_c, fs_c;
  logic [SW-1:0]    sig_s_c, mask_c, al_c;
  logic             spec_c, inv_c;
  logic [W-1:0]     sres_c;

  always_comb begin
    sa_c = bus.i_fp1[W-1];
    ea_c = bus.i_fp1[W-2:MAN_W];
    fa_c = bus.i_fp1[MAN_W-1:0];
    sb_c = bus.i_fp2[W-1] ^ bus.i_sub;
    eb_c = bus.i_fp2[W-2:MAN_W];
    fb_c = bus.i_fp2[MAN_W-1:0];

    nan_a_c  = (ea_c == EXP_ONES) && (fa_c != '0);
    nan_b_c  = (eb_c == EXP_ONES) && (fb_c != '0);
    snan_a_c = nan_a_c && !fa_c[MAN_W-1];
    snan_b_c = nan_b_c && !fb_c[MAN_W-1];
    inf_a_c  = (ea_c == EXP_ONES) && (fa_c == '0);
    inf_b_c  = (eb_c == EXP_ONES) && (fb_c == '0);

    swap_c = {eb_c, fb_c} > {ea_c, fa_c};
    sl_c   = swap_c ? sb_c : sa_c;
    el_c   = swap_c ? eb_c : ea_c;
    fl_c   = swap_c ? fb_c : fa_c;
    es_c   = swap_c ? ea_c : eb_c;
    fs_c   = swap_c ? fa_c : fb_c;
    hl_c   = (el_c != '0);
    hs_c   = (es_c != '0);
    if (!hl_c) el_c = EXP_W'(1);
    if (!hs_c) es_c = EXP_W'(1);

    d_c     = el_c - es_c;
    sig_s_c = {hs_c, fs_c, 3'b000};
    mask_c  = (SW'(1) << d_c) - SW'(1);
    if (32'(d_c) >= SH_LIM) al_c = SW'(|sig_s_c);
    else                    al_c = (sig_s_c >> d_c) | SW'(|(sig_s_c & mask_c));

    spec_c = nan_a_c | nan_b_c | inf_a_c | inf_b_c;
    inv_c  = 1'b0;
    sres_c = QNAN;
    if (nan_a_c || nan_b_c)                         inv_c = snan_a_c | snan_b_c;
    else if (inf_a_c && inf_b_c && (sa_c != sb_c))  inv_c = 1'b1;
    else if (inf_a_c)                               sres_c = {sa_c, EXP_ONES, {MAN_W{1'b0}}};
    else if (inf_b_c)                               sres_c = {sb_c, EXP_ONES, {MAN_W{1'b0}}};
  end

  logic             s1_spec, s1_inv, s1_sign, s1_sub;
  logic [W-1:0]     s1_res;
  logic [EXP_W-1:0] s1_exp;
  logic [SW-1:0]    s1_siga, s1_sigb;

  // S2: magnitude add/subtract with one carry bit
  logic [SW:0] sum_c;
  logic        sign2_c;

  always_comb begin
    if (s1_sub) sum_c = {1'b0, s1_siga} - {1'b0, s1_sigb};
    else        sum_c = {1'b0, s1_siga} + {1'b0, s1_sigb};
    sign2_c = (s1_sub && (sum_c == '0)) ? 1'b0 : s1_sign;
  end

  logic             s2_spec, s2_inv, s2_sign;
  logic [W-1:0]     s2_res;
  logic [EXP_W-1:0] s2_exp;
  logic [SW:0]      s2_sum;

  function automatic logic [31:0] lzc(input logic [SW-1:0] x);
    logic [31:0] n;
    n = 32'(SW);
    for (int unsigned i = 0; i < SW; i++) begin
      if (x[i]) n = 32'(SW - 1 - i);
    end
    return n;
  endfunction

  // S3: normalise, round, pack
  logic [SW-1:0]    m_c;
  logic [XW-1:0]    en_c, er_c;
  logic [31:0]      lz_c, lim_c, sh_c;
  logic             inexact_c, rup_c, ovf_c;
  logic [MAN_W+1:0] rnd_c;
  logic [MAN_W-1:0] fr_c;
  logic [W-1:0]     res_c;
  logic [3:0]       flags_c;

  always_comb begin
    lz_c  = lzc(s2_sum[SW-1:0]);
    lim_c = 32'(s2_exp) - 32'd1;
    sh_c  = (lz_c < lim_c) ? lz_c : lim_c;
    if (s2_sum[SW]) begin
      m_c  = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
      en_c = XW'(s2_exp) + XW'(1);
    end else begin
      m_c  = s2_sum[SW-1:0] << sh_c;
      en_c = m_c[SW-1] ? XW'(32'(s2_exp) - sh_c) : '0;
    end

    inexact_c = m_c[2] | m_c[1] | m_c[0];
`ifdef FP_ADD_RNE_EN
    rup_c = m_c[2] & (m_c[1] | m_c[0] | m_c[3]);
`else
    rup_c = 1'b0;
`endif
    rnd_c = {1'b0, m_c[SW-1:3]} + (MAN_W+2)'(rup_c);
    if (rnd_c[MAN_W+1]) begin
      er_c = en_c + XW'(1);
      fr_c = rnd_c[MAN_W:1];
    end else begin
      er_c = ((en_c == '0) && rnd_c[MAN_W]) ? XW'(1) : en_c;
      fr_c = rnd_c[MAN_W-1:0];
    end
    ovf_c = (er_c >= XW'(EXP_ONES));

    if (s2_spec) begin
      res_c   = s2_res;
      flags_c = {s2_inv, 3'b000};
    end else if (ovf_c) begin
`ifdef FP_ADD_RNE_EN
      res_c = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
`else
      res_c = {s2_sign, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
`endif
      flags_c = 4'b0101;
    end else begin
      res_c   = {s2_sign, er_c[EXP_W-1:0], fr_c};
      flags_c = {1'b0, 1'b0, (er_c == '0) && inexact_c, inexact_c};
    end
  end

  // Control and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_fp    <= '0;
      bus.o_flags <= '0;
    end else begin
      if (en1_c) v1 <= in_fire_c;
      if (en2_c) v2 <= v1;
      if (en3_c) begin
        bus.o_valid <= v2;
        if (v2) begin
          bus.o_fp    <= res_c;
          bus.o_flags <= flags_c;
        end
      end
    end
  end

  // Datapath stage registers
  always_ff @(posedge i_clk) begin
    if (in_fire_c) begin
      s1_spec <= spec_c;
      s1_inv  <= inv_c;
      s1_res  <= sres_c;
      s1_sign <= sl_c;
      s1_sub  <= sa_c ^ sb_c;
      s1_exp  <= el_c;
      s1_siga <= {hl_c, fl_c, 3'b000};
      s1_sigb <= al_c;
    end
    if (en2_c && v1) begin
      s2_spec <= s1_spec;
      s2_inv  <= s1_inv;
      s2_res  <= s1_res;
      s2_sign <= sign2_c;
      s2_exp  <= s1_exp;
      s2_sum  <= sum_c;
    end
  end
endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed self-checking bench for fp_adder_pipe: FP32 and BF16 instances on one clock.
module tb_fp_adder_pipe;
`ifdef FP_ADD_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  fp_adder_pipe_if #(.EXP_W(8), .MAN_W(23)) b32 ();
  fp_adder_pipe_if #(.EXP_W(8), .MAN_W(7))  b16 ();

  fp_adder_pipe #(.EXP_W(8), .MAN_W(23)) u_dut32 (.i_clk(clk), .i_rst(rst), .bus(b32));
  fp_adder_pipe #(.EXP_W(8), .MAN_W(7))  u_dut16 (.i_clk(clk), .i_rst(rst), .bus(b16));

  logic [31:0] in_tab  [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] out_tab [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                               32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One isolated transaction: latency, result and flags
  task automatic run_vec(input string tag, input bit bf, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] e_fp, input logic [3:0] e_fl);
    int lat;
    if (bf) begin
      b16.i_fp1 = a[15:0]; b16.i_fp2 = b[15:0]; b16.i_sub = sub; b16.i_valid = 1'b1;
    end else begin
      b32.i_fp1 = a; b32.i_fp2 = b; b32.i_sub = sub; b32.i_valid = 1'b1;
    end
    #1;
    check({tag, "_rdy"}, 64'(bf ? b16.o_ready : b32.o_ready), 64'd1);
    @(posedge clk); #1;
    b16.i_valid = 1'b0;
    b32.i_valid = 1'b0;
    lat = 1;
    while (!(bf ? b16.o_valid : b32.o_valid) && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check({tag, "_fp"}, bf ? 64'(b16.o_fp) : 64'(b32.o_fp), 64'(e_fp));
    check({tag, "_fl"}, bf ? 64'(b16.o_flags) : 64'(b32.o_flags), 64'(e_fl));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, recv, cyc, stalls;
    bit in_fire;

    rst = 1'b1;
    b32.i_valid = 1'b0; b32.i_ready = 1'b1; b32.i_fp1 = '0; b32.i_fp2 = '0; b32.i_sub = 1'b0;
    b16.i_valid = 1'b0; b16.i_ready = 1'b1; b16.i_fp1 = '0; b16.i_fp2 = '0; b16.i_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_valid32", 64'(b32.o_valid), 64'd0);
    check("rst_fp32",    64'(b32.o_fp),    64'd0);
    check("rst_fl32",    64'(b32.o_flags), 64'd0);
    check("rst_rdy32",   64'(b32.o_ready), 64'd1);
    check("rst_valid16", 64'(b16.o_valid), 64'd0);
    check("rst_rdy16",   64'(b16.o_ready), 64'd1);
    @(posedge clk); #1;

    run_vec("one_plus_one", 0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0);
    run_vec("one_sub_one",  0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0);
    run_vec("negz_negz",    0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0);
    run_vec("posz_negz",    0, 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0);
    run_vec("inf_minf",     0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8);
    run_vec("snan",         0, 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8);
    run_vec("inf_fin",      0, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0);
    run_vec("ovf",          0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0,
            RNE ? 32'h7F800000 : 32'h7F7FFFFF, 4'h5);
    run_vec("grs_up",       0, 32'h3F800000, 32'h33C00000, 1'b0,
            RNE ? 32'h3F800001 : 32'h3F800000, 4'h1);
    run_vec("tie_even",     0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1);
    run_vec("tie_odd",      0, 32'h3F800001, 32'h33800000, 1'b0,
            RNE ? 32'h3F800002 : 32'h3F800001, 4'h1);
    run_vec("sticky_only",  0, 32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'h1);
    run_vec("subn_add",     0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'h0);
    run_vec("subn_cancel",  0, 32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 4'h0);
    run_vec("three_m_one",  0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0);
    run_vec("neg_result",   0, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0);

    // Back-to-back stream with a 5-cycle output stall
    sent = 0; recv = 0; cyc = 0; stalls = 0;
    while (recv < 8 && cyc < 60) begin
      b32.i_ready = !(cyc >= 4 && cyc < 9);
      b32.i_valid = (sent < 8);
      b32.i_sub   = 1'b0;
      if (sent < 8) begin
        b32.i_fp1 = in_tab[sent];
        b32.i_fp2 = in_tab[sent];
      end
      #1;
      in_fire = b32.i_valid && b32.o_ready;
      if (b32.o_valid && b32.i_ready) begin
        check("strm_fp", 64'(b32.o_fp), 64'(out_tab[recv]));
        check("strm_fl", 64'(b32.o_flags), 64'd0);
        recv++;
      end else if (b32.o_valid) begin
        stalls++;
        check("stall_fp",  64'(b32.o_fp), 64'(out_tab[recv]));
        check("stall_fl",  64'(b32.o_flags), 64'd0);
        check("stall_rdy", 64'(b32.o_ready), 64'd0);
      end
      @(posedge clk); #1;
      if (in_fire) sent++;
      cyc++;
    end
    b32.i_valid = 1'b0;
    b32.i_ready = 1'b1;
    check("strm_cnt",    64'(recv),   64'd8);
    check("strm_stalls", 64'(stalls), 64'd5);
    check("strm_drain",  64'(b32.o_valid), 64'd0);

    // Reset with two results in flight
    b32.i_fp1 = 32'h3F800000; b32.i_fp2 = 32'h3F800000; b32.i_sub = 1'b0; b32.i_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b32.i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_valid", 64'(b32.o_valid), 64'd0);
    check("mrst_fp",    64'(b32.o_fp),    64'd0);
    check("mrst_rdy",   64'(b32.o_ready), 64'd1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("mrst_drop", 64'(b32.o_valid), 64'd0);
    end

    run_vec("bf_one_plus_one", 1, 32'h3F80, 32'h3F80, 1'b0, 32'h4000, 4'h0);
    run_vec("bf_one_sub_one",  1, 32'h3F80, 32'h3F80, 1'b1, 32'h0000, 4'h0);
    run_vec("bf_tie_even",     1, 32'h3F80, 32'h3B80, 1'b0, 32'h3F80, 4'h1);
    run_vec("bf_ovf",          1, 32'h7F7F, 32'h7F7F, 1'b0, RNE ? 32'h7F80 : 32'h7F7F, 4'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
